// File: rtl/visualizador_pkg.sv
// Shared constants and types for the multiplexed 4-digit need-level display.
package visualizador_pkg;

    localparam int NIVEL_W = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ALL   = 7'h00;

    localparam logic [1:0] DIG_ANIMO  = 2'd0;
    localparam logic [1:0] DIG_HAMBRE = 2'd1;
    localparam logic [1:0] DIG_SUENO  = 2'd2;
    localparam logic [1:0] DIG_SALUD  = 2'd3;

    typedef struct packed {
        logic [NIVEL_W-1:0] animo;
        logic [NIVEL_W-1:0] hambre;
        logic [NIVEL_W-1:0] sueno;
        logic [NIVEL_W-1:0] salud;
        logic               dormido;
        logic               test;
    } snap_t;

    // Active-low one-hot anode for a digit index.
    function automatic logic [3:0] anodo(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/visualizador_estados_decodificador_7seg.sv
// Level (0..7) to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module decodificador_7seg
    import visualizador_pkg::*;
(
    input  logic [NIVEL_W-1:0] nivel,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nivel)
            3'd0: seg = 7'h40;
            3'd1: seg = 7'h79;
            3'd2: seg = 7'h24;
            3'd3: seg = 7'h30;
            3'd4: seg = 7'h19;
            3'd5: seg = 7'h12;
            3'd6: seg = 7'h02;
            3'd7: seg = 7'h78;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/visualizador_estados.sv
// Multiplexed common-anode display of the four need levels with critical blink,
// sleep view and lamp test. One coherent input snapshot is shown per frame.
module visualizador_estados
    import visualizador_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned BLINK_DIV = 12_500_000,
    parameter int unsigned CRIT      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NIVEL_W-1:0] nivel_animo,
    input  logic [NIVEL_W-1:0] nivel_hambre,
    input  logic [NIVEL_W-1:0] nivel_sueno,
    input  logic [NIVEL_W-1:0] nivel_salud,
    input  logic               dormido,
    input  logic               test,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               dp
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0]      SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0]      BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [NIVEL_W-1:0] CRIT_N    = NIVEL_W'(CRIT);

    logic [SW-1:0]      scan_cnt_q;
    logic [BW-1:0]      blink_cnt_q;
    logic [1:0]         d_q;
    logic               phase_q;
    logic               primero_q;
    snap_t              snap_q;
    snap_t              snap_in;
    logic [6:0]         seg_q, seg_d, seg_dec;
    logic [3:0]         an_q, an_d;
    logic               dp_q, dp_d;
    logic [NIVEL_W-1:0] nivel_sel;
    logic               scan_tc, blink_tc, critico;

    assign snap_in = '{animo: nivel_animo, hambre: nivel_hambre, sueno: nivel_sueno,
                       salud: nivel_salud, dormido: dormido, test: test};

    assign scan_tc  = (scan_cnt_q == SCAN_MAX);
    assign blink_tc = (blink_cnt_q == BLINK_MAX);

    always_comb begin
        nivel_sel = snap_q.animo;
        unique case (d_q)
            DIG_ANIMO:  nivel_sel = snap_q.animo;
            DIG_HAMBRE: nivel_sel = snap_q.hambre;
            DIG_SUENO:  nivel_sel = snap_q.sueno;
            DIG_SALUD:  nivel_sel = snap_q.salud;
            default:    nivel_sel = snap_q.animo;
        endcase
    end

    decodificador_7seg u_dec (
        .nivel (nivel_sel),
        .seg   (seg_dec)
    );

    assign critico = (nivel_sel <= CRIT_N);

    // Blank on the first cycle (no snapshot yet) and whenever the digit index moves.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!primero_q && !scan_tc) begin
            an_d = anodo(d_q);
            if (snap_q.test) begin
                seg_d = SEG_ALL;
                dp_d  = 1'b0;
            end else if (snap_q.dormido && d_q != DIG_SUENO) begin
                seg_d = SEG_DASH;
            end else if (critico) begin
                seg_d = phase_q ? SEG_BLANK : seg_dec;
                dp_d  = 1'b0;
            end else begin
                seg_d = seg_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            d_q         <= 2'd0;
            phase_q     <= 1'b0;
            primero_q   <= 1'b1;
            snap_q      <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
            dp_q        <= 1'b1;
        end else begin
            if (blink_tc) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end

            // The scan holds on the snapshot cycle so digit 0 gets a full slot.
            if (primero_q) begin
                primero_q <= 1'b0;
                snap_q    <= snap_in;
            end else if (scan_tc) begin
                scan_cnt_q <= '0;
                d_q        <= d_q + 2'd1;
                if (d_q == DIG_SALUD) begin
                    snap_q <= snap_in;
                end
            end else begin
                scan_cnt_q <= scan_cnt_q + SW'(1);
            end

            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: doc/visualizador_estados.md
# visualizador_estados

Multiplexed 4-digit 7-segment driver that displays the pet's four need levels (ánimo, hambre, sueño, salud) produced by the state stage. It sits directly downstream of the state stage and replaces the single-bit need LEDs with numeric levels, a critical-level blink, a sleep view and a lamp test. Outputs drive a common-anode display with active-low segments and anodes.

## Interface

Parameters:
- SCAN_DIV, 50_000 — clk cycles per digit slot (1 kHz per digit at 50 MHz).
- BLINK_DIV, 12_500_000 — clk cycles per blink phase (2 Hz blink at 50 MHz).
- CRIT, 1 — levels ≤ CRIT are critical.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- nivel_animo  in  3  ánimo level, 0..7.
- nivel_hambre  in  3  hambre level, 0..7.
- nivel_sueno  in  3  sueño level, 0..7.
- nivel_salud  in  3  salud level, 0..7.
- dormido  in  1  pet asleep, active-high.
- test  in  1  lamp test, active-high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low. an[0]=ánimo, an[1]=hambre, an[2]=sueño, an[3]=salud.
- dp  out  1  decimal point, active-low.

## Operation

- **Scan counter:** counts 0..SCAN_DIV-1. At the terminal count, digit index d (2 bits) increments and wraps 3→0.
- **Snapshot:** the four levels, dormido and test are registered into a snapshot on the first cycle after reset and on every cycle where d wraps 3→0. A whole frame displays a single coherent snapshot; input changes mid-frame take effect at the next frame.
- **Anti-ghost blanking:** in the cycle d changes, an=4'b1111. The new digit is driven from the following cycle.
- **Blink:** blink counter counts 0..BLINK_DIV-1. At the terminal count, blink phase toggles (reset phase = 0 = visible). It runs freely and is independent of the scan.
- **Per-digit content, priority high→low:**
  - test: seg=7'h00, dp=0, for every digit.
  - dormido: digit 2 shows nivel_sueno; digits 0, 1 and 3 show dash 7'h3F; dp=1.
  - critical (level ≤ CRIT): dp=0. seg = decoded digit when phase=0, blank 7'h7F when phase=1. The anode stays active.
  - normal: seg = decoded level, dp=1.
- **Decoder (active-low):**
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - Constants: blank=7'h7F, dash=7'h3F, all-on=7'h00.
- **Critical during dormido:** criticality still blinks digit 2 under dormido. Digits 0, 1 and 3 stay dash.

## Timing

- **Reset values:** an=4'b1111, seg=7'h7F, dp=1. Scan counter, blink counter, d and phase all 0.
- All outputs are registered. Pins reflect the current d and snapshot with one cycle latency.
- **After reset deassertion:**
  - Cycle 0: snapshot taken.
  - Cycle 1: an=4'b1110, showing the snapshot.
  - Each digit is then active for SCAN_DIV-1 cycles, followed by 1 blank cycle.
  - Frame period = 4·SCAN_DIV cycles.
- **Reset asserted mid-frame:** next clock returns every register to its reset value. No partial digit completes.
- **Coincident events:** a digit change and a blink toggle in the same cycle both apply. The blank cycle wins for that cycle.
- **test:** sampled only at the snapshot, so lamp test starts or stops at a frame boundary.
- **Width and wrap:** levels are 3-bit, so no out-of-range values exist. The counters' terminal counts are exactly SCAN_DIV-1 and BLINK_DIV-1. Requirements: SCAN_DIV ≥ 2, BLINK_DIV ≥ 1.

## Structure

- **Shared package `visualizador_pkg`:**
  - Segment constants: SEG_BLANK, SEG_DASH, SEG_ALL.
  - Digit-index localparams: DIG_ANIMO=0, DIG_HAMBRE=1, DIG_SUENO=2, DIG_SALUD=3.
  - Level width: NIVEL_W=3.
- **Sub-module `decodificador_7seg`:** combinational, 3-bit level → 7-bit active-low pattern. It is the only natural split.
- Scan, snapshot, blink and output muxing stay in the top of this block.

## Test plan

Bench parameters: SCAN_DIV=4, BLINK_DIV=16, CRIT=1.

1. **Reset then scan:** levels 3/5/6/7, dormido=0, test=0, reset released.
   - Cycle 1: an=1110, seg=7'h30.
   - Cycle 4: an=1111.
   - Cycle 5: an=1101, seg=7'h12.
   - Sequence continues through an=1011 (7'h02) and 0111 (7'h78), frame period 16.
2. **Snapshot coherence:** change nivel_animo 3→4 while d=2.
   - Digit 0 still shows 7'h30 if the change falls after that frame's snapshot.
   - Next frame's digit 0 shows 7'h19.
3. **Critical blink:** nivel_salud=1, others 4.
   - Digit 3 has dp=0.
   - seg alternates between 7'h79 (phase 0) and 7'h7F (phase 1), phase toggling every 16 cycles.
   - Other digits show 7'h19, dp=1.
4. **Dormido:** dormido=1, nivel_sueno=2, others 5.
   - Digits 0, 1 and 3 show 7'h3F.
   - Digit 2 shows 7'h24.
5. **Lamp test priority:** test=1 together with dormido=1 and nivel_salud=0.
   - From the next frame, every digit shows seg=7'h00, dp=0.
6. **Reset mid-digit:** assert reset while an=1011.
   - Next cycle: an=1111, seg=7'h7F, dp=1.
   - After release, the scan restarts at digit 0.
